// File: rtl/binary_mul_acc.sv
// binary_mul_acc
//   Accumulates N consecutive unsigned products from the array multiplier's
//   P register. The completed frame sum is handed on over a valid/ready
//   interface. While a result waits, the next frame's first product is taken
//   in the same cycle the result is consumed, so frames stream back to back.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear      synchronous frame abort; same register values as reset
//   in_valid   in_p carries a product
//   in_ready   block accepts in_p this cycle
//   in_p       unsigned product, P_W bits
//   out_valid  out_sum holds a completed frame sum
//   out_ready  consumer takes out_sum this cycle
//   out_sum    registered sum of N products, ACC_W bits
//   frame_cnt  products accepted in the current frame
module binary_mul_acc #(
    parameter int P_W   = 8,
    parameter int N     = 4,
    parameter int ACC_W = P_W + $clog2(N),
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_beat;
    logic               out_beat;
    logic [ACC_W-1:0]   p_ext;
    logic               last_beat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs
    always_comb begin
        out_valid = (state_q == ST_DONE);
        // While a result is held, input is only taken when that result is
        // consumed in the same cycle.
        in_ready  = (state_q == ST_ACC) ? 1'b1 : out_ready;
        out_sum   = sum_q;
        frame_cnt = cnt_q;
    end

    // Gate the product with in_valid so an undriven bus never reaches the adder.
    assign p_ext     = in_valid ? ACC_W'(in_p) : '0;
    assign in_beat   = in_valid && in_ready;
    assign out_beat  = out_valid && out_ready;
    assign last_beat = (cnt_q == CNT_W'(N - 1));

    // Next-state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            sum_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_beat) begin
                        if (last_beat) begin
                            sum_d   = acc_q + p_ext;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            acc_d = acc_q + p_ext;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_beat) begin
                        if (in_beat) begin
                            // First product of the next frame rides the
                            // same cycle; with N==1 it is a whole frame.
                            if (N > 1) begin
                                acc_d   = p_ext;
                                cnt_d   = CNT_W'(1);
                                state_d = ST_ACC;
                            end else begin
                                sum_d   = p_ext;
                            end
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

endmodule
